// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha keystream datapath: FSM encoding,
// default geometry, and the block-counter step used by the core and the XOR stage.
package chacha_pkg;

  localparam int KS_WORDS_DEF = 16;
  localparam int DW_DEF       = 32;
  localparam int CTR_W        = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FILL  = 2'd2,
    ST_SERVE = 2'd3
  } chacha_state_e;

  // Block counter advances modulo 2^32 (all-ones wraps to zero).
  function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] c);
    return c + CTR_W'(1);
  endfunction

endpackage

// File: rtl/chacha_ks_buf.sv
// Keystream block storage: one synchronous write port, one asynchronous read
// port. Contents are deliberately not reset; the fill index guards validity.
module chacha_ks_buf #(
  parameter int KS_WORDS = 16,
  parameter int DW       = 32,
  parameter int AW       = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [KS_WORDS];

  // Capture one keystream word per strobe.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/chacha_ks_xor.sv
// Keystream XOR stage: requests a ChaCha block, buffers its words, then XORs
// them one-for-one with the incoming data stream, prefetching the next block
// as soon as the last buffered word has been consumed.
module chacha_ks_xor
  import chacha_pkg::*;
#(
  parameter int KS_WORDS = KS_WORDS_DEF,
  parameter int DW       = DW_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ctr_load,
  input  logic [CTR_W-1:0] ctr_init,
  output logic             blk_req,
  output logic [CTR_W-1:0] blk_ctr,
  input  logic             ks_valid,
  input  logic [DW-1:0]    ks_word,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             busy,
  output logic             ks_err
);

  localparam int            AW       = (KS_WORDS > 1) ? $clog2(KS_WORDS) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(KS_WORDS - 1);

  chacha_state_e state, state_nxt;

  logic [AW-1:0]    fill_idx;
  logic [AW-1:0]    rd_idx;
  logic [DW-1:0]    buf_rdata;
  logic             buf_we;
  logic             fill_done;
  logic             ld_take;
  logic             ks_bad;
  logic             accept;
  logic             rd_last;

  logic             vld_p1;
  logic [DW-1:0]    out_data_p1;

  chacha_ks_buf #(
    .KS_WORDS (KS_WORDS),
    .DW       (DW),
    .AW       (AW)
  ) u_ks_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (fill_idx),
    .wdata (ks_word),
    .raddr (rd_idx),
    .rdata (buf_rdata)
  );

  assign blk_req   = (state == ST_REQ);
  assign busy      = (state != ST_IDLE);
  assign in_ready  = (state == ST_SERVE) && (!vld_p1 || out_ready);
  assign accept    = in_valid && in_ready;
  assign rd_last   = (rd_idx == LAST_IDX);
  assign fill_done = buf_we && (fill_idx == LAST_IDX);
  assign out_valid = vld_p1;
  assign out_data  = out_data_p1;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the per-cycle control strobes that steer the datapath.
  always_comb begin
    state_nxt = state;
    ld_take   = 1'b0;
    buf_we    = 1'b0;
    ks_bad    = 1'b0;
    case (state)
      ST_IDLE: begin
        ks_bad = ks_valid;
        if (ctr_load) begin
          ld_take = 1'b1;
        end else if (in_valid) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // The word arriving on the REQ->FILL edge is word 0, not a stray.
        if (ctr_load) begin
          ld_take   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (ks_valid) begin
          buf_we    = 1'b1;
          state_nxt = (fill_idx == LAST_IDX) ? ST_SERVE : ST_FILL;
        end
      end
      ST_FILL: begin
        // Counter loads are ignored here so a block in flight is never torn.
        if (ks_valid) begin
          buf_we = 1'b1;
          if (fill_idx == LAST_IDX) begin
            state_nxt = ST_SERVE;
          end
        end
      end
      ST_SERVE: begin
        ks_bad = ks_valid;
        if (ctr_load) begin
          ld_take   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (accept && rd_last) begin
          state_nxt = ST_REQ;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Block counter, buffer indices and sticky keystream error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_ctr  <= '0;
      fill_idx <= '0;
      rd_idx   <= '0;
      ks_err   <= 1'b0;
    end else if (ld_take) begin
      blk_ctr  <= ctr_init;
      fill_idx <= '0;
      rd_idx   <= '0;
      ks_err   <= 1'b0;
    end else begin
      if (ks_bad) begin
        ks_err <= 1'b1;
      end
      if (buf_we) begin
        fill_idx <= fill_done ? '0 : fill_idx + AW'(1);
      end
      if (accept) begin
        if (rd_last) begin
          rd_idx  <= '0;
          blk_ctr <= ctr_next(blk_ctr);
        end else begin
          rd_idx <= rd_idx + AW'(1);
        end
      end
    end
  end

  // Output stage: hold until drained, refill on the same edge for no bubble.
  // A word accepted alongside a counter load is still delivered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1      <= 1'b0;
      out_data_p1 <= '0;
    end else if (accept) begin
      vld_p1      <= 1'b1;
      out_data_p1 <= in_data ^ buf_rdata;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chacha_ks_xor.sv
module tb_chacha_ks_xor;

  localparam int KS = 16;

  logic        clk = 1'b0;
  logic        reset_n, ctr_load, ks_valid, in_valid, in_ready;
  logic        out_valid, out_ready, blk_req, busy, ks_err;
  logic [31:0] ctr_init, blk_ctr, ks_word, in_data, out_data;

  logic        core_ks_valid, man_ks_valid;
  logic [31:0] core_ks_word, man_ks_word;

  int checks = 0;
  int errors = 0;
  int blocks_allowed = 0;
  int blocks_served  = 0;
  int req_rises      = 0;
  int ks_mode        = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] ctr_init;
    int          nblocks;
    int          rdy_mode;
    int          ks_md;
    logic [31:0] exp_ctr;
  } vec_t;

  vec_t vecs[5];

  assign ks_valid = core_ks_valid | man_ks_valid;
  assign ks_word  = man_ks_valid ? man_ks_word : core_ks_word;

  always #5 clk = ~clk;

  chacha_ks_xor #(.KS_WORDS(KS), .DW(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ctr_load  (ctr_load),
    .ctr_init  (ctr_init),
    .blk_req   (blk_req),
    .blk_ctr   (blk_ctr),
    .ks_valid  (ks_valid),
    .ks_word   (ks_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .ks_err    (ks_err)
  );

  // Keystream a well-behaved core would return for block counter c, word i.
  function automatic logic [31:0] ks_fn(input logic [31:0] c, input int i);
    if (ks_mode == 0) return 32'h1000 + 32'(i);
    return (c * 32'h9E3779B9) ^ {c[15:0], 16'(i)} ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fake ChaCha core: answers blk_req with one block, random inter-word gaps.
  initial begin : core
    logic [31:0] c;
    core_ks_valid = 1'b0;
    core_ks_word  = '0;
    forever begin
      @(negedge clk);
      if (reset_n && blk_req && blocks_served < blocks_allowed) begin
        c = blk_ctr;
        for (int i = 0; i < KS; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1; core_ks_valid = 1'b0;
          end
          @(posedge clk); #1;
          core_ks_valid = 1'b1;
          core_ks_word  = ks_fn(c, i);
        end
        @(posedge clk); #1;
        core_ks_valid = 1'b0;
        blocks_served++;
      end
    end
  end

  initial begin : req_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (blk_req === 1'b1 && !prev) req_rises++;
      prev = (blk_req === 1'b1);
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int base_rises;
    n = v.nblocks * KS;
    ctr_init = v.ctr_init;
    ctr_load = 1'b1;
    tick();
    ctr_load = 1'b0;
    ks_mode = v.ks_md;
    base_rises = req_rises;
    blocks_allowed = blocks_served + v.nblocks;
    exp_q.delete();
    fork
      begin : producer
        for (int k = 0; k < n; k++) begin
          int wait_cyc;
          logic [31:0] c;
          if (v.rdy_mode == 2) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk); #1; in_valid = 1'b0;
            end
          end
          @(posedge clk); #1;
          in_valid = 1'b1;
          in_data  = $urandom;
          wait_cyc = 0;
          forever begin
            @(negedge clk);
            if (in_ready) break;
            if (wait_cyc > 300) break;
            @(posedge clk); #1;
            wait_cyc++;
          end
          if (!in_ready) begin
            checks++; errors++;
            $display("FAIL vec%0d in_ready timeout: word %0d of %0d", idx, k, n);
            break;
          end
          c = v.ctr_init + 32'(k / KS);
          exp_q.push_back(in_data ^ ks_fn(c, k % KS));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin : consumer
        int got, cyc;
        logic stall;
        logic [31:0] hold, e;
        got = 0; cyc = 0; stall = 1'b0; hold = '0;
        while (got < n && cyc < 4000) begin
          @(posedge clk); #1;
          case (v.rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
          endcase
          @(negedge clk);
          if (stall) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", out_data, hold);
          end
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL vec%0d extra_output: got %h expected none", idx, out_data);
            end else begin
              e = exp_q.pop_front();
              chk("out_data", out_data, e);
            end
            got++;
          end
          stall = out_valid && !out_ready;
          hold  = out_data;
          cyc++;
        end
        if (got < n) begin
          checks++; errors++;
          $display("FAIL vec%0d output_timeout: got %0d words required %0d", idx, got, n);
        end
      end
    join
    repeat (3) tick();
    chk("blk_ctr_end", blk_ctr, v.exp_ctr);
    chk("blk_req_prefetch", {31'd0, blk_req}, 32'd1);
    chk("req_rises", 32'(req_rises - base_rises), 32'(v.nblocks + 1));
    chk("drained", {31'd0, out_valid}, 32'd0);
    chk("in_ready_req", {31'd0, in_ready}, 32'd0);
    chk("ks_err_clean", {31'd0, ks_err}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_blk_ctr"}, blk_ctr, 32'd0);
    chk({tag, "_blk_req"}, {31'd0, blk_req}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ks_err"}, {31'd0, ks_err}, 32'd0);
  endtask

  task automatic man_fill(input logic [31:0] base, input int from, input int to);
    for (int i = from; i < to; i++) begin
      man_ks_valid = 1'b1;
      man_ks_word  = base + 32'(i);
      tick();
    end
    man_ks_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'd5,          1, 0, 0, 32'd6};
    vecs[1] = '{32'hFFFFFFFF,   1, 0, 1, 32'h00000000};
    vecs[2] = '{32'd20,         1, 1, 1, 32'd21};
    vecs[3] = '{32'hFFFFFFFE,   3, 2, 1, 32'h00000001};
    vecs[4] = '{32'h12345678,   2, 2, 1, 32'h1234567A};

    reset_n = 1'b0; ctr_load = 1'b0; ctr_init = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    man_ks_valid = 1'b0; man_ks_word = '0;
    repeat (2) tick();
    check_reset_vals("rst_hold");
    reset_n = 1'b1;
    tick();
    check_reset_vals("rst_rel");

    // Stray keystream in IDLE is sticky until a counter load.
    man_ks_valid = 1'b1; man_ks_word = 32'hDEAD;
    tick();
    man_ks_valid = 1'b0;
    chk("ks_err_set", {31'd0, ks_err}, 32'd1);
    repeat (3) tick();
    chk("ks_err_sticky", {31'd0, ks_err}, 32'd1);
    ctr_init = 32'd7; ctr_load = 1'b1;
    tick();
    ctr_load = 1'b0;
    chk("ks_err_clr", {31'd0, ks_err}, 32'd0);
    chk("load_idle_ctr", blk_ctr, 32'd7);

    // Load during FILL is ignored; load during SERVE returns to IDLE.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("req_blk_req", {31'd0, blk_req}, 32'd1);
    chk("req_in_ready", {31'd0, in_ready}, 32'd0);
    man_fill(32'hA000, 0, 8);
    ctr_init = 32'd99; ctr_load = 1'b1;
    tick();
    ctr_load = 1'b0;
    chk("fill_load_ctr", blk_ctr, 32'd7);
    chk("fill_load_busy", {31'd0, busy}, 32'd1);
    chk("fill_blk_req", {31'd0, blk_req}, 32'd0);
    man_fill(32'hA000, 8, KS);
    out_ready = 1'b1;
    chk("serve_in_ready", {31'd0, in_ready}, 32'd1);
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      in_data  = 32'h11110000 + 32'(j);
      tick();
      chk("serve_out_data", out_data, (32'h11110000 + 32'(j)) ^ (32'hA000 + 32'(j)));
    end
    in_valid = 1'b0;
    ctr_init = 32'd42; ctr_load = 1'b1;
    tick();
    ctr_load = 1'b0;
    chk("serve_load_busy", {31'd0, busy}, 32'd0);
    chk("serve_load_ctr", blk_ctr, 32'd42);

    // Load coinciding with the last word of a block: load wins, word still emitted.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    man_fill(32'hB000, 0, KS);
    for (int j = 0; j < KS - 1; j++) begin
      in_valid = 1'b1;
      in_data  = 32'(j);
      tick();
    end
    in_data = 32'hCAFE; ctr_init = 32'h55; ctr_load = 1'b1;
    tick();
    in_valid = 1'b0; ctr_load = 1'b0;
    chk("last_load_valid", {31'd0, out_valid}, 32'd1);
    chk("last_load_data", out_data, 32'hCAFE ^ 32'hB00F);
    chk("last_load_ctr", blk_ctr, 32'h55);
    chk("last_load_busy", {31'd0, busy}, 32'd0);
    tick();

    for (int v = 0; v < 5; v++) run_vec(vecs[v], v);

    ctr_init = 32'd0; ctr_load = 1'b1;
    tick();
    ctr_load = 1'b0;

    // Asynchronous reset in SERVE with a pending output.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    man_fill(32'hC000, 0, KS);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h5;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    tick();
    reset_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chacha_ks_xor.md
CHACHA_KS_XOR -- requirements
Module: chacha_ks_xor

Interface
REQ-001 SHALL have parameter KS_WORDS, default 16, keystream words per ChaCha block.
REQ-002 SHALL have parameter DW, default 32, data and keystream word width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 ctr_load  in  1  single-cycle pulse; loads block counter and flushes buffer.
REQ-007 ctr_init  in  32  block counter value loaded on ctr_load.
REQ-008 blk_req  out  1  level request to ChaCha core for one keystream block.
REQ-009 blk_ctr  out  32  block counter of the requested/current block.
REQ-010 ks_valid  in  1  core keystream word strobe, no backpressure.
REQ-011 ks_word  in  DW  keystream word; word 0 first.
REQ-012 in_valid / in_ready  in / out  1 / 1  plaintext handshake.
REQ-013 in_data  in  DW  plaintext (or ciphertext) word.
REQ-014 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-015 out_data  out  DW  in_data XOR keystream word.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 ks_err  out  1  sticky; ks_valid seen outside FILL.

Function
REQ-018 SHALL implement FSM IDLE, REQ, FILL, SERVE.
REQ-019 IDLE->REQ when in_valid=1; REQ: blk_req=1 until first ks_valid, then FILL and blk_req=0 the same edge.
REQ-020 A ks_valid in the same cycle REQ->FILL is taken SHALL be stored as word 0.
REQ-021 FILL SHALL store each ks_valid word at fill index 0..KS_WORDS-1; after word KS_WORDS-1 -> SERVE, read index=0.
REQ-022 SERVE: in_ready = (!out_valid || out_ready); an in_valid&in_ready transfer SHALL register out_data = in_data ^ buf[idx] and set out_valid next cycle (1-cycle latency).
REQ-023 out_valid SHALL stay high with stable out_data until out_ready=1; simultaneous new accept and drain SHALL produce back-to-back outputs with no bubble.
REQ-024 On consuming word KS_WORDS-1: blk_ctr increments modulo 2^32 (0xFFFFFFFF->0) and state -> REQ (prefetch, regardless of in_valid).
REQ-025 in_ready SHALL be 0 in IDLE, REQ, FILL; a pending out_valid word SHALL still drain in those states.
REQ-026 ctr_load in IDLE, REQ or SERVE: blk_ctr<=ctr_init, buffer indices cleared, ks_err cleared, state->IDLE, blk_req=0 next cycle; pending out_valid word is retained.
REQ-027 ctr_load in FILL SHALL be ignored entirely (no field changes).
REQ-028 ctr_load coinciding with a SERVE transfer of word KS_WORDS-1: load wins, no increment; the transferred word is still output.
REQ-029 ks_valid in IDLE, REQ-free SERVE states (IDLE, SERVE) SHALL be discarded and set ks_err.

Reset
REQ-030 reset_n=0 SHALL asynchronously force: state IDLE, blk_ctr=0, blk_req=0, out_valid=0, out_data=0, in_ready=0, busy=0, ks_err=0, indices 0.
REQ-031 Reset mid-FILL SHALL discard all buffered words; keystream buffer contents need not be reset.

Structure
REQ-032 Package chacha_pkg SHALL hold the FSM state enum, KS_WORDS and DW defaults, shared with the ChaCha core.
REQ-033 Keystream storage SHALL be one sub-module chacha_ks_buf (KS_WORDS x DW, 1 write port, 1 async read port, no reset).

Verification
REQ-034 ctr_init=5 load, in_valid held, core streams 16 words 0x1000+i -> blk_req once, 16 outputs in_data^0x1000+i, blk_ctr=6, blk_req reasserted after word 15.
REQ-035 ctr_init=0xFFFFFFFF, consume one full block -> blk_ctr=0x00000000.
REQ-036 out_ready toggled 1/0 every cycle over 16 words -> no loss, no duplicates, out_data stable while stalled.
REQ-037 ctr_load pulsed in FILL after 8 words -> ignored, FILL completes, blk_ctr unchanged; ctr_load in SERVE after 3 words -> IDLE, blk_ctr=ctr_init.
REQ-038 ks_valid pulse in IDLE -> ks_err=1, stays 1 until ctr_load; reset_n low mid-SERVE -> all outputs at reset values immediately.
